// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the instruction-fetch handshake and
// retires into sequential, redirect or halt. Define PC_ALIGN_CHECK_EN to trap misaligned redirects.
module pc_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   output logic            instr_valid,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_target,
   input  logic            halt_req,
   input  logic            resume,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            fault
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

   logic [1:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic            retire;
   logic            resume_ok;

   assign retire = (state_q == ST_ISSUE) && !stall;

`ifdef PC_ALIGN_CHECK_EN
   logic misaligned;

   assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign resume_ok  = resume && !fault_q;

   always_comb begin
      pc_d    = pc_q;
      fault_d = fault_q;
      if (retire) begin
         if (misaligned) begin
            fault_d = 1'b1;
         end else if (redirect_valid) begin
            pc_d = redirect_target;
         end else begin
            pc_d = pc_q + STEP;
         end
      end
   end
`else
   logic [PC_W-1:0] aligned_target;
   logic            misaligned;
   logic            unused_target_lsb;

   // Low address bits are dropped so every fetch stays word aligned.
   assign aligned_target    = {redirect_target[PC_W-1:2], 2'b00};
   assign unused_target_lsb = ^redirect_target[1:0];
   assign misaligned        = 1'b0;
   assign resume_ok         = resume;

   always_comb begin
      pc_d    = pc_q;
      fault_d = 1'b0;
      if (retire) begin
         if (redirect_valid) begin
            pc_d = aligned_target;
         end else begin
            pc_d = pc_q + STEP;
         end
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (!stall) begin
               // A misaligned redirect halts regardless of halt_req.
               if (misaligned || halt_req) state_d = ST_HALT;
               else                        state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
            if (resume_ok) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   // Handshake outputs are forced low during reset so a pending fetch is abandoned.
   assign imem_req    = !reset && (state_q == ST_FETCH);
   assign instr_valid = !reset && (state_q == ST_ISSUE);
   assign halted      = !reset && (state_q == ST_HALT);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign fault       = fault_q;

endmodule
